muldiv_seq: RTL

Multi-cycle HI/LO sequencer for the MIPS EX stage. Owns the HI and LO registers and executes MULT, MULTU, DIV and DIVU iteratively over 32 cycles. Executes MTHI and MTLO in a single cycle. Raises a stall to the pipeline whenever an instruction that touches HI/LO issues while an operation is in flight. The EX stage reads HI/LO from this block for MFHI/MFLO and no longer holds those registers itself.

---
 rtl/muldiv_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// HI/LO owner for the EX stage: iterative MULT/MULTU/DIV/DIVU over 32 cycles,
// single-cycle MTHI/MTLO, and a combinational stall for HI/LO users while busy.
module muldiv_seq (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic [5:0]  func,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   input  logic        flush,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic        dz
);

   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state_q, state_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [32:0] acc_q, acc_d;   // mul: upper product half; div: partial remainder
   logic [31:0] q_q, q_d;       // mul: multiplier; div: dividend/quotient
   logic [31:0] b_q, b_d;       // |multiplicand| or |divisor|
   logic [31:0] a_q, a_d;       // original opa, returned in HI on divide-by-zero
   logic        div_q, div_d, sa_q, sa_d, sb_q, sb_d;
   logic        done_q, done_d, dz_q, dz_d;

   logic        sa_new, sb_new;
   logic [31:0] abs_a, abs_b;
   logic [32:0] mul_sum;
   logic [33:0] div_diff;
   logic [63:0] prod, prod_fix;
   logic [31:0] quo_fix, rem_fix;

   // Signed ops (even func codes) work on magnitudes; 0x80000000 stays 0x80000000.
   assign sa_new = ~func[0] & opa[31];
   assign sb_new = ~func[0] & opb[31];
   assign abs_a  = sa_new ? -opa : opa;
   assign abs_b  = sb_new ? -opb : opb;

   assign mul_sum  = {1'b0, acc_q[31:0]} + (q_q[0] ? {1'b0, b_q} : 33'd0);
   assign div_diff = {acc_q, q_q[31]} - {2'b00, b_q};

   assign prod     = {acc_q[31:0], q_q};
   assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;
   assign quo_fix  = (sa_q ^ sb_q) ? -q_q : q_q;
   assign rem_fix  = sa_q ? -acc_q[31:0] : acc_q[31:0];

   assign busy  = (state_q != IDLE);
   assign stall = start & busy & ((func[5:2] == 4'b0100) | (func[5:2] == 4'b0110));
   assign HI    = hi_q;
   assign LO    = lo_q;
   assign done  = done_q;
   assign dz    = dz_q;

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      q_d     = q_q;
      b_d     = b_q;
      a_d     = a_q;
      div_d   = div_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      done_d  = 1'b0;
      dz_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               case (func)
                  F_MTHI: hi_d = opa;
                  F_MTLO: lo_d = opa;
                  F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                     sa_d    = sa_new;
                     sb_d    = sb_new;
                     q_d     = abs_a;
                     b_d     = abs_b;
                     a_d     = opa;
                     acc_d   = '0;
                     cnt_d   = '0;
                     div_d   = func[1];
                     state_d = CALC;
                  end
                  default: ;
               endcase
            end
         end
         CALC: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               if (div_q) begin
                  if (!div_diff[33]) begin
                     acc_d = div_diff[32:0];
                     q_d   = {q_q[30:0], 1'b1};
                  end else begin
                     acc_d = {acc_q[31:0], q_q[31]};
                     q_d   = {q_q[30:0], 1'b0};
                  end
               end else begin
                  acc_d = {1'b0, mul_sum[32:1]};
                  q_d   = {mul_sum[0], q_q[31:1]};
               end
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_d = FIX;
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!flush) begin
               done_d = 1'b1;
               if (!div_q) begin
                  {hi_d, lo_d} = prod_fix;
               end else if (b_q == '0) begin
                  lo_d = '1;
                  hi_d = a_q;
                  dz_d = 1'b1;
               end else begin
                  lo_d = quo_fix;
                  hi_d = rem_fix;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         b_q     <= '0;
         a_q     <= '0;
         div_q   <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         b_q     <= b_d;
         a_q     <= a_d;
         div_q   <= div_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

endmodule
